// File: rtl/osfm_dot_accumulator.sv
// ---------------------------------------------------------------------------
// osfm_dot_accumulator
//
// Streaming dot-product stage built around the OSFM approximate multiplier.
// It accepts one unsigned (a,b) operand pair per cycle, multiplies each pair
// through an OSFM instance, sums VEC_LEN consecutive products and presents
// one result per vector on a valid/ready output. It sits between the
// weight/activation operand feed and the activation/requantise stage.
//
// OSFM multiplier (osfm_mult below)
//   Each operand is reduced to one of two static fragments of width W/2:
//   - if its upper half is non-zero, the upper half is kept and the lower
//     half is discarded (the operand is truncated to a multiple of 2^(W/2));
//   - otherwise the lower half is kept exactly.
//   The two fragments are multiplied exactly, re-aligned, and the upper W
//   bits of the 2W-bit product are returned (a W-bit fixed-point product).
//   W must be even.
//
// Parameters
//   VEC_LEN  products per vector (>= 2)
//   ACC_W    accumulator / result width (>= `BITWIDTH); wrap-free when
//            ACC_W >= `BITWIDTH + $clog2(VEC_LEN)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   acc_clr    in   synchronous abort of the partial vector
//   in_valid   in   operand pair valid
//   in_ready   out  operand pair accepted when in_valid && in_ready
//   in_a       in   operand a, unsigned, `BITWIDTH bits
//   in_b       in   operand b, unsigned, `BITWIDTH bits
//   out_valid  out  result valid
//   out_ready  in   result consumed when out_valid && out_ready
//   out_sum    out  dot-product result, unsigned, ACC_W bits
//   out_sat    out  result was clamped (only with OSFM_DOT_SAT_EN)
//
// Configuration macro: OSFM_DOT_SAT_EN
//   undefined : accumulator and out_sum wrap modulo 2^ACC_W, no out_sat port.
//   defined   : an add that carries out of ACC_W clamps the accumulator to
//               all-ones for the rest of the vector and sets a sticky flag
//               that is reported on out_sat with the result.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   out_valid, once raised, stays high with out_sum stable until consumed.
//   in_ready depends only on the output side: in_ready = !(out_valid &&
//   !out_ready). in_valid is never required to wait for in_ready.
// ---------------------------------------------------------------------------

`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module osfm_mult #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  localparam int M = W / 2;

  logic           hi_a;
  logic           hi_b;
  logic [M-1:0]   seg_a;
  logic [M-1:0]   seg_b;
  logic [W-1:0]   seg_p;
  logic [2*W-1:0] full_p;

  assign hi_a  = |a[W-1:M];
  assign hi_b  = |b[W-1:M];
  assign seg_a = hi_a ? a[W-1:M] : a[M-1:0];
  assign seg_b = hi_b ? b[W-1:M] : b[M-1:0];
  assign seg_p = {{M{1'b0}}, seg_a} * {{M{1'b0}}, seg_b};

  // Re-align the fragment product by the total weight of the kept fragments.
  always_comb begin
    full_p = '0;
    unique case ({hi_a, hi_b})
      2'b00:   full_p = {{W{1'b0}}, seg_p};
      2'b01,
      2'b10:   full_p = {{W{1'b0}}, seg_p} << M;
      2'b11:   full_p = {{W{1'b0}}, seg_p} << (2 * M);
      default: full_p = '0;
    endcase
  end

  assign p = full_p[2*W-1:W];

endmodule

module osfm_dot_accumulator #(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = `BITWIDTH + 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [`BITWIDTH-1:0] in_a,
  input  logic [`BITWIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum
`ifdef OSFM_DOT_SAT_EN
  ,
  output logic                 out_sat
`endif
);

  localparam int W     = `BITWIDTH;
  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  // Handshake / control
  logic stall;
  logic accept;
  logic acc_step;
  logic complete;

  // E0 operand stage
  logic         v0;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  // E1 product stage
  logic         v1;
  logic [W-1:0] osfm_p;
  logic [W-1:0] prod_q;

  // E2 accumulator
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_next;

  // A pending unconsumed result freezes the whole pipeline.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // acc_clr takes priority over any accumulation in the same cycle.
  assign acc_step = v1 && !stall && !acc_clr;
  assign complete = acc_step && (cnt == LAST);

  // ---------------------------------------------------------------------
  // E0: capture accepted operands
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0  <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else if (acc_clr) begin
      // A pair handshaked in the same cycle as acc_clr is dropped.
      v0 <= 1'b0;
    end else if (!stall) begin
      v0 <= accept;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

  // ---------------------------------------------------------------------
  // E1: approximate multiply (combinational) and register the product
  // ---------------------------------------------------------------------
  osfm_mult #(
    .W (W)
  ) u_osfm (
    .a (a_q),
    .b (b_q),
    .p (osfm_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      prod_q <= '0;
    end else if (acc_clr) begin
      v1 <= 1'b0;
    end else if (!stall) begin
      v1     <= v0;
      prod_q <= osfm_p;
    end
  end

  // ---------------------------------------------------------------------
  // E2: accumulate; the product is zero-extended to ACC_W before the add
  // ---------------------------------------------------------------------
`ifdef OSFM_DOT_SAT_EN
  logic [ACC_W:0] sum_full;
  logic           sat_q;
  logic           sat_next;

  assign sum_full = {1'b0, acc} + (ACC_W + 1)'(prod_q);

  // Once a vector overflows it stays clamped until the flag clears.
  always_comb begin
    sat_next = sat_q | sum_full[ACC_W];
    acc_next = sat_next ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  end
`else
  assign acc_next = acc + ACC_W'(prod_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
`ifdef OSFM_DOT_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (acc_clr) begin
      acc   <= '0;
      cnt   <= '0;
`ifdef OSFM_DOT_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (acc_step) begin
      if (cnt == LAST) begin
        acc   <= '0;
        cnt   <= '0;
`ifdef OSFM_DOT_SAT_EN
        sat_q <= 1'b0;
`endif
      end else begin
        acc   <= acc_next;
        cnt   <= cnt + CNT_W'(1);
`ifdef OSFM_DOT_SAT_EN
        sat_q <= sat_next;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result register. Completion wins over consumption: a result finishing
  // in the cycle the previous one is taken simply replaces it.
  // acc_clr does not touch a pending result.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef OSFM_DOT_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else if (complete) begin
      out_valid <= 1'b1;
      out_sum   <= acc_next;
`ifdef OSFM_DOT_SAT_EN
      out_sat   <= sat_next;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_osfm_dot_accumulator.sv
// ---------------------------------------------------------------------------
// tb_osfm_dot_accumulator
//
// Drives two instances with identical stimulus: a wide one (ACC_W =
// `BITWIDTH+8) and a narrow one (ACC_W = `BITWIDTH) used for wrap/clamp
// behaviour. Expected results come from a vector-level model: each accepted
// pair contributes the approximate product (operands truncated to their
// leading half-width fragment, exact product, upper half kept); every
// VEC_LEN accepted pairs form one vector whose integer sum is then wrapped
// (or clamped with OSFM_DOT_SAT_EN) to the accumulator width.
// ---------------------------------------------------------------------------

`timescale 1ns/1ps

`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module tb_osfm_dot_accumulator;

  localparam int W          = `BITWIDTH;
  localparam int VEC_LEN    = 16;
  localparam int ACC_WIDE   = W + 8;
  localparam int ACC_NARROW = W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                  acc_clr   = 1'b0;
  logic                  in_valid  = 1'b0;
  logic [W-1:0]          in_a      = '0;
  logic [W-1:0]          in_b      = '0;
  logic                  out_ready = 1'b1;

  logic                  in_ready;
  logic                  out_valid;
  logic [ACC_WIDE-1:0]   out_sum;
  logic                  n_in_ready;
  logic                  n_out_valid;
  logic [ACC_NARROW-1:0] n_out_sum;
`ifdef OSFM_DOT_SAT_EN
  logic                  out_sat;
  logic                  n_out_sat;
`endif

  osfm_dot_accumulator #(
    .VEC_LEN (VEC_LEN),
    .ACC_W   (ACC_WIDE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_clr   (acc_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
`ifdef OSFM_DOT_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  osfm_dot_accumulator #(
    .VEC_LEN (VEC_LEN),
    .ACC_W   (ACC_NARROW)
  ) dut_n (
    .clk       (clk),
    .rst       (rst),
    .acc_clr   (acc_clr),
    .in_valid  (in_valid),
    .in_ready  (n_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (n_out_valid),
    .out_ready (out_ready),
    .out_sum   (n_out_sum)
`ifdef OSFM_DOT_SAT_EN
    ,
    .out_sat   (n_out_sat)
`endif
  );

  // ---------------- bookkeeping ----------------
  int compares  = 0;
  int mism      = 0;
  int n_results = 0;
  int cyc       = 0;
  int res_cyc_q[$];
  logic [ACC_NARROW-1:0] last_n_sum;
  logic                  last_n_sat;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic longint unsigned osfm_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned frag;
    longint unsigned aa;
    longint unsigned bb;
    frag = longint'(1) << (W / 2);
    aa = a;
    bb = b;
    if (aa >= frag) aa = aa - (aa % frag);
    if (bb >= frag) bb = bb - (bb % frag);
    return (aa * bb) >> W;
  endfunction

  function automatic longint unsigned fold(input longint unsigned total, input int acc_w);
    longint unsigned maxv;
    maxv = (longint'(1) << acc_w) - 1;
`ifdef OSFM_DOT_SAT_EN
    return (total > maxv) ? maxv : total;
`else
    return total & maxv;
`endif
  endfunction

  logic [ACC_WIDE-1:0]   exp_w_q[$];
  logic [ACC_NARROW-1:0] exp_n_q[$];
  logic                  exp_ws_q[$];
  logic                  exp_ns_q[$];
  int                    part_n   = 0;
  longint unsigned       part_sum = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      part_n   = 0;
      part_sum = 0;
      exp_w_q.delete();
      exp_n_q.delete();
      exp_ws_q.delete();
      exp_ns_q.delete();
    end else if (acc_clr) begin
      part_n   = 0;
      part_sum = 0;
    end else if (in_valid && in_ready) begin
      part_sum = part_sum + osfm_ref(in_a, in_b);
      part_n   = part_n + 1;
      if (part_n == VEC_LEN) begin
        exp_w_q.push_back(ACC_WIDE'(fold(part_sum, ACC_WIDE)));
        exp_n_q.push_back(ACC_NARROW'(fold(part_sum, ACC_NARROW)));
        exp_ws_q.push_back(part_sum > ((longint'(1) << ACC_WIDE) - 1));
        exp_ns_q.push_back(part_sum > ((longint'(1) << ACC_NARROW) - 1));
        part_n   = 0;
        part_sum = 0;
      end
    end
  end

  // ---------------- scoreboard / checker ----------------
  always @(negedge clk) begin
    logic [ACC_WIDE-1:0]   ew;
    logic [ACC_NARROW-1:0] en;
    logic                  ews;
    logic                  ens;
    if (!rst) begin
      compares++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        mism++;
        $display("FAIL in_ready rule: got %b, need %b (out_valid=%b out_ready=%b) t=%0t",
                 in_ready, !(out_valid && !out_ready), out_valid, out_ready, $time);
      end
      compares++;
      if (n_out_valid !== out_valid || n_in_ready !== in_ready) begin
        mism++;
        $display("FAIL narrow timing: out_valid %b vs %b, in_ready %b vs %b t=%0t",
                 n_out_valid, out_valid, n_in_ready, in_ready, $time);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_results++;
        res_cyc_q.push_back(cyc);
        last_n_sum = n_out_sum;
`ifdef OSFM_DOT_SAT_EN
        last_n_sat = n_out_sat;
`else
        last_n_sat = 1'b0;
`endif
        compares++;
        if (exp_w_q.size() == 0) begin
          mism++;
          $display("FAIL unexpected result: got sum %0d, none expected t=%0t", out_sum, $time);
        end else begin
          ew  = exp_w_q.pop_front();
          en  = exp_n_q.pop_front();
          ews = exp_ws_q.pop_front();
          ens = exp_ns_q.pop_front();
          if (out_sum !== ew) begin
            mism++;
            $display("FAIL out_sum: got %0d, need %0d t=%0t", out_sum, ew, $time);
          end
          compares++;
          if (n_out_sum !== en) begin
            mism++;
            $display("FAIL narrow out_sum: got %0d, need %0d t=%0t", n_out_sum, en, $time);
          end
`ifdef OSFM_DOT_SAT_EN
          compares++;
          if (out_sat !== ews || n_out_sat !== ens) begin
            mism++;
            $display("FAIL out_sat: got %b/%b, need %b/%b t=%0t", out_sat, n_out_sat, ews, ens, $time);
          end
`else
          if (ews !== ews || ens !== ens) mism = mism;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int  waited;
    bit  ok;
    waited   = 0;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!ok && waited < 200);
    if (!ok) begin
      compares++;
      mism++;
      $display("FAIL send_pair: pair not accepted after %0d cycles, need acceptance", waited);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    in_valid = 1'b0;
    while ((exp_w_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    compares++;
    if (exp_w_q.size() != 0 || out_valid) begin
      mism++;
      $display("FAIL %s drain: %0d results outstanding, need 0", tag, exp_w_q.size());
    end
  endtask

  task automatic check_count(input string tag, input int got, input int need);
    compares++;
    if (got !== need) begin
      mism++;
      $display("FAIL %s result count: got %0d, need %0d", tag, got, need);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base;
    // Power-on state
    compares++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || n_out_sum !== '0) begin
      mism++;
      $display("FAIL reset state: out_valid=%b in_ready=%b out_sum=%0d, need 0/1/0",
               out_valid, in_ready, out_sum);
    end
    // Reset mid-vector after 5 pairs
    for (int i = 0; i < 5; i++) send_pair(W'($urandom), W'($urandom));
    idle(1);
    rst = 1'b1;
    #1;
    compares++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mism++;
      $display("FAIL mid reset: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = n_results;
    for (int i = 0; i < VEC_LEN; i++) send_pair(W'($urandom), W'($urandom));
    wait_drain("reset");
    check_count("reset", n_results - base, 1);
  endtask

  task automatic test_zero_vector();
    int base;
    base = n_results;
    for (int i = 0; i < VEC_LEN; i++) send_pair('0, W'(8'hFF));
    in_valid = 1'b0;
    // Now 1 ns after the edge that accepted the 16th pair.
    compares++;
    if (out_valid !== 1'b0) begin
      mism++;
      $display("FAIL zero latency E+0: out_valid=%b, need 0", out_valid);
    end
    @(posedge clk);
    #1;
    compares++;
    if (out_valid !== 1'b0) begin
      mism++;
      $display("FAIL zero latency E+1: out_valid=%b, need 0", out_valid);
    end
    @(posedge clk);
    #1;
    compares++;
    if (out_valid !== 1'b1 || out_sum !== '0) begin
      mism++;
      $display("FAIL zero latency E+2: out_valid=%b out_sum=%0d, need 1/0", out_valid, out_sum);
    end
    @(posedge clk);
    #1;
    compares++;
    if (out_valid !== 1'b0) begin
      mism++;
      $display("FAIL zero single pulse: out_valid=%b, need 0", out_valid);
    end
    wait_drain("zero");
    check_count("zero", n_results - base, 1);
  endtask

  task automatic test_streaming();
    int base;
    base = n_results;
    res_cyc_q.delete();
    for (int i = 0; i < 3 * VEC_LEN; i++) send_pair(W'($urandom), W'($urandom));
    wait_drain("stream");
    check_count("stream", n_results - base, 3);
    for (int i = 1; i < res_cyc_q.size(); i++) begin
      compares++;
      if (res_cyc_q[i] - res_cyc_q[i-1] != VEC_LEN) begin
        mism++;
        $display("FAIL stream spacing: got %0d cycles, need %0d", res_cyc_q[i] - res_cyc_q[i-1], VEC_LEN);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = n_results;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * VEC_LEN; i++) send_pair(W'($urandom), W'($urandom));
        in_valid = 1'b0;
      end
      begin
        int t;
        logic [ACC_WIDE-1:0] held;
        t = 0;
        while (out_valid !== 1'b1 && t < 200) begin
          @(negedge clk);
          t++;
        end
        compares++;
        if (out_valid !== 1'b1) begin
          mism++;
          $display("FAIL backpressure: no result within %0d cycles, need one", t);
        end
        held = out_sum;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          compares++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held) begin
            mism++;
            $display("FAIL backpressure hold %0d: in_ready=%b out_valid=%b out_sum=%0d, need 0/1/%0d",
                     k, in_ready, out_valid, out_sum, held);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
    check_count("backpressure", n_results - base, 2);
  endtask

  task automatic test_acc_clr();
    int base;
    logic [ACC_WIDE-1:0] held;
    // Abort on the 7th pair, which is handshaked in the same cycle.
    base = n_results;
    for (int i = 0; i < 6; i++) send_pair(W'($urandom), W'($urandom));
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_valid = 1'b1;
    acc_clr  = 1'b1;
    @(posedge clk);
    #1;
    acc_clr  = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) send_pair(W'($urandom), W'($urandom));
    wait_drain("acc_clr");
    check_count("acc_clr", n_results - base, 1);

    // Abort while a result is pending: the result must survive.
    base = n_results;
    out_ready = 1'b0;
    for (int i = 0; i < VEC_LEN + 2; i++) send_pair(W'($urandom), W'($urandom));
    idle(3);
    held    = out_sum;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    compares++;
    if (out_valid !== 1'b1 || out_sum !== held) begin
      mism++;
      $display("FAIL acc_clr pending: out_valid=%b out_sum=%0d, need 1/%0d", out_valid, out_sum, held);
    end
    out_ready = 1'b1;
    wait_drain("acc_clr pending");
    for (int i = 0; i < VEC_LEN; i++) send_pair(W'($urandom), W'($urandom));
    wait_drain("acc_clr after");
    check_count("acc_clr pending", n_results - base, 2);
  endtask

  task automatic test_wrap_sat();
    logic [W-1:0]          ones;
    longint unsigned       total;
    logic [ACC_NARROW-1:0] need;
    ones  = '1;
    total = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      send_pair(ones, ones);
      total = total + osfm_ref(ones, ones);
    end
    wait_drain("max vector");
`ifdef OSFM_DOT_SAT_EN
    need = '1;
    compares++;
    if (last_n_sat !== 1'b1) begin
      mism++;
      $display("FAIL max vector sat: got %b, need 1", last_n_sat);
    end
`else
    need = ACC_NARROW'(total);
`endif
    compares++;
    if (last_n_sum !== need) begin
      mism++;
      $display("FAIL max vector narrow sum: got %0d, need %0d", last_n_sum, need);
    end
    for (int i = 0; i < VEC_LEN; i++) send_pair('0, '0);
    wait_drain("zero after max");
    compares++;
    if (last_n_sum !== '0 || last_n_sat !== 1'b0) begin
      mism++;
      $display("FAIL zero after max: sum=%0d sat=%b, need 0/0", last_n_sum, last_n_sat);
    end
  endtask

  task automatic test_random_handshake();
    int  base;
    bit  done;
    base = n_results;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * VEC_LEN; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send_pair(W'($urandom), W'($urandom));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int t;
        t = 0;
        while (!done && t < 2000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
          t++;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random");
    check_count("random", n_results - base, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_zero_vector();
    test_streaming();
    test_backpressure();
    test_acc_clr();
    test_wrap_sat();
    test_random_handshake();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

  initial begin
    #500000;
    mism++;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
